// File: rtl/dac_thresh_loader.sv
`timescale 1ns/1ps
// dac_thresh_loader
//   Serialises one 16-bit threshold word {2'b00, ADDR, DATA} to a SPI-style
//   DAC (MSB first). The frame is followed by an LDAC_N strobe that moves the
//   new code onto the comparator threshold input.
//
// Ports
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   LOAD     single-cycle write request, ADDR/DATA sampled with it
//   ADDR     DAC channel select (2 bits)
//   DATA     threshold code (12 bits)
//   BUSY     high while a frame is in progress
//   DONE     one-cycle pulse when a frame completes
//   OVERRUN  one-cycle pulse, one cycle after a LOAD that arrived while busy
//   CS_N     DAC chip select, active-low
//   SCLK     DAC serial clock, idle low, half-period CLK_DIV cycles
//   SDI      DAC serial data, held at 0 while CS_N is high
//   LDAC_N   DAC latch strobe, active-low, CLK_DIV cycles wide
//
// Every output is a flop. Its next value is derived from the next state, so
// it lines up with the state register without a combinational input path.
module dac_thresh_loader #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [1:0]  ADDR,
    input  logic [11:0] DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN,
    output logic        CS_N,
    output logic        SCLK,
    output logic        SDI,
    output logic        LDAC_N
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LATCH,
        FIN
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_q, phase_d;    // 0: SCLK low half of a bit, 1: high half
    logic [15:0] frame_q, frame_d;
    logic        rdy_q, rdy_d;        // blocks LOAD on the first edge after reset
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic        ldac_n_q, ldac_n_d;

    logic        div_last;
    logic [3:0]  bit_idx;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        frame_d  = frame_q;
        rdy_d    = 1'b1;
        sclk_d   = sclk_q;
        sdi_d    = sdi_q;
        div_last = (div_q == DIV_LAST);
        bit_idx  = bit_q[3:0] - 4'd1;
        ovr_d    = LOAD && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (LOAD && rdy_q) begin
                    frame_d = {2'b00, ADDR, DATA};
                    state_d = SETUP;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    sdi_d   = frame_d[15];
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT;
                    bit_d   = 5'd15;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        // Falling SCLK: the only point where SDI moves on.
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_q == '0) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = {1'b0, bit_idx};
                            sdi_d = frame_q[bit_idx];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = LATCH;
                    sdi_d   = 1'b0;   // CS_N rises on the same edge
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = FIN;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
        cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        ldac_n_d = (state_d != LATCH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            frame_q  <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            frame_q  <= frame_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            ldac_n_q <= ldac_n_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVERRUN = ovr_q;
    assign CS_N    = cs_n_q;
    assign SCLK    = sclk_q;
    assign SDI     = sdi_q;
    assign LDAC_N  = ldac_n_q;

endmodule
